// File: rtl/qam_demapper_pkg.sv
// Shared types and helpers for the 16QAM receive front end.
package qam_demapper_pkg;

    localparam int SAMPLE_W = 8;
    localparam int DIFF_W   = SAMPLE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic signed [SAMPLE_W-1:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)
            return 8'sh7f;
        else if (v < -32'sd128)
            return 8'sh80;
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/qam_iq_accum.sv
// One I or Q rail: DC offset register, offset correction, integrate-and-dump with saturation.
module qam_iq_accum
    import qam_demapper_pkg::*;
#(
    parameter int SPS_LOG2 = 2,
    parameter int CAL_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       clear,
    input  logic                       acc_en,
    input  logic                       cal_mode,
    input  logic                       dump,
    input  logic                       cal_last,
    output logic signed [SAMPLE_W-1:0] out
);

    // One accumulator serves both the calibration sum and the symbol sum.
    localparam int ACC_W = (DIFF_W + SPS_LOG2 > SAMPLE_W + CAL_LOG2) ?
                           (DIFF_W + SPS_LOG2) : (SAMPLE_W + CAL_LOG2);

    logic signed [SAMPLE_W-1:0] off;
    logic signed [DIFF_W-1:0]   diff;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    addend;
    logic signed [ACC_W-1:0]    sum_next;
    logic signed [31:0]         sum_wide;

    always_comb begin
        diff     = {sample[SAMPLE_W-1], sample} - {off[SAMPLE_W-1], off};
        addend   = cal_mode ? {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample}
                            : {{(ACC_W-DIFF_W){diff[DIFF_W-1]}}, diff};
        sum_next = acc + addend;
        sum_wide = {{(32-ACC_W){sum_next[ACC_W-1]}}, sum_next};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            off <= '0;
            out <= '0;
        end else begin
            if (clear || dump || cal_last)
                acc <= '0;
            else if (acc_en)
                acc <= sum_next;
            if (dump)
                out <= sat8(sum_wide >>> SPS_LOG2);
            // Mean of 8-bit samples always fits, so sat8 only narrows here.
            if (cal_last)
                off <= sat8(sum_wide >>> CAL_LOG2);
        end
    end

endmodule

// File: rtl/qam_symbol_integrator.sv
// Integrate-and-dump front end: DC calibration, per-symbol averaging, strobes for the demapper.
module qam_symbol_integrator
    import qam_demapper_pkg::*;
#(
    parameter int SPS_LOG2 = 2,
    parameter int CAL_LOG2 = 4
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cal,
    input  logic signed [SAMPLE_W-1:0] I_in,
    input  logic signed [SAMPLE_W-1:0] Q_in,
    output logic signed [SAMPLE_W-1:0] I_out,
    output logic signed [SAMPLE_W-1:0] Q_out,
    output logic                       sym_valid,
    output logic                       cal_done,
    output logic                       busy
);

    localparam int CNT_W = (SPS_LOG2 > CAL_LOG2) ? SPS_LOG2 : CAL_LOG2;
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'((1 << SPS_LOG2) - 1);
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             run_go, acc_en, cal_mode, clear, dump, cal_last;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cal)
                    state_nxt = ST_CAL;
                else if (en)
                    state_nxt = ST_RUN;
            end
            ST_CAL:  if (cnt == CAL_LAST) state_nxt = ST_IDLE;
            ST_RUN: begin
                if (cal)
                    state_nxt = ST_CAL;
                else if (!en)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A sample on the edge that leaves RUN is not accepted; the partial symbol is dropped.
    always_comb begin
        run_go   = (state == ST_RUN) && en && !cal;
        cal_mode = (state == ST_CAL);
        acc_en   = cal_mode || run_go;
        clear    = !acc_en;
        dump     = run_go && (cnt == SYM_LAST);
        cal_last = cal_mode && (cnt == CAL_LAST);
        busy     = (state != ST_IDLE);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            sym_valid <= 1'b0;
            cal_done  <= 1'b0;
        end else begin
            if (clear || dump || cal_last)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            sym_valid <= dump;
            cal_done  <= cal_last;
        end
    end

    qam_iq_accum #(.SPS_LOG2(SPS_LOG2), .CAL_LOG2(CAL_LOG2)) u_i (
        .clk(sclk), .rst(rst), .sample(I_in),
        .clear(clear), .acc_en(acc_en), .cal_mode(cal_mode),
        .dump(dump), .cal_last(cal_last), .out(I_out)
    );

    qam_iq_accum #(.SPS_LOG2(SPS_LOG2), .CAL_LOG2(CAL_LOG2)) u_q (
        .clk(sclk), .rst(rst), .sample(Q_in),
        .clear(clear), .acc_en(acc_en), .cal_mode(cal_mode),
        .dump(dump), .cal_last(cal_last), .out(Q_out)
    );

endmodule

// File: tb/tb_qam_symbol_integrator.sv
// Directed bench: table of 4-sample symbols plus hand sequences for calibration, abort, priority and reset.
module tb_qam_symbol_integrator;

    logic              sclk = 1'b0;
    logic              rst;
    logic              en;
    logic              cal;
    logic signed [7:0] I_in;
    logic signed [7:0] Q_in;
    logic signed [7:0] I_out;
    logic signed [7:0] Q_out;
    logic              sym_valid;
    logic              cal_done;
    logic              busy;

    int ncmp = 0;
    int nerr = 0;

    qam_symbol_integrator dut (
        .sclk(sclk), .rst(rst), .en(en), .cal(cal),
        .I_in(I_in), .Q_in(Q_in),
        .I_out(I_out), .Q_out(Q_out),
        .sym_valid(sym_valid), .cal_done(cal_done), .busy(busy)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic signed [7:0] iv [4];
        logic signed [7:0] qv [4];
        int                ei;
        int                eq;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(int a0, int a1, int a2, int a3,
                                int b0, int b1, int b2, int b3, int ei, int eq);
        vec_t v;
        v.iv[0] = 8'(a0); v.iv[1] = 8'(a1); v.iv[2] = 8'(a2); v.iv[3] = 8'(a3);
        v.qv[0] = 8'(b0); v.qv[1] = 8'(b1); v.qv[2] = 8'(b2); v.qv[3] = 8'(b3);
        v.ei = ei;
        v.eq = eq;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic e, input logic c, input int i, input int q);
        en   = e;
        cal  = c;
        I_in = 8'(i);
        Q_in = 8'(q);
        @(posedge sclk);
        #1;
    endtask

    // Four accepted samples in RUN; strobe must appear only after the fourth.
    task automatic sym4(input string name, input vec_t v);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, int'(v.iv[k]), int'(v.qv[k]));
            if (k < 3) chk({name, " sym_valid low"}, int'(sym_valid), 0);
        end
        chk({name, " sym_valid"}, int'(sym_valid), 1);
        chk({name, " I_out"}, int'(I_out), v.ei);
        chk({name, " Q_out"}, int'(Q_out), v.eq);
    endtask

    // Enter CAL from IDLE and feed 16 constant samples.
    task automatic calibrate(input string name, input int i, input int q, input logic with_en);
        int pulses = 0;
        tick(with_en, 1'b1, i, q);
        chk({name, " busy in CAL"}, int'(busy), 1);
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, i, q);
            pulses += int'(cal_done);
            chk({name, " no sym_valid in CAL"}, int'(sym_valid), 0);
        end
        chk({name, " cal_done on 16th"}, int'(cal_done), 1);
        chk({name, " idle after CAL"}, int'(busy), 0);
        tick(1'b0, 1'b0, 0, 0);
        chk({name, " cal_done one cycle"}, int'(cal_done), 0);
        chk({name, " cal_done pulses"}, pulses, 1);
    endtask

    initial begin
        vecs[0] = mk(10, 10, 10, 10, -20, -20, -20, -20, 10, -20);
        vecs[1] = mk(-1, -2, -1, -2, 1, 2, 1, 2, -2, 1);
        vecs[2] = mk(127, 127, 127, 127, -128, -128, -128, -128, 127, -128);
        vecs[3] = mk(3, 0, 0, 0, -3, 0, 0, 0, 0, -1);
        vecs[4] = mk(100, -100, 50, -50, 7, 7, 7, 6, 0, 6);
        vecs[5] = mk(-128, 127, -128, 127, 1, 0, 0, 0, -1, 0);

        rst = 1'b1; en = 1'b0; cal = 1'b0; I_in = '0; Q_in = '0;
        #2;
        chk("reset I_out", int'(I_out), 0);
        chk("reset Q_out", int'(Q_out), 0);
        chk("reset sym_valid", int'(sym_valid), 0);
        chk("reset cal_done", int'(cal_done), 0);
        chk("reset busy", int'(busy), 0);
        #10 rst = 1'b0;

        // Continuous RUN with zero offsets: back-to-back symbols from the table.
        tick(1'b1, 1'b0, 0, 0);
        chk("enter RUN busy", int'(busy), 1);
        for (int n = 0; n < 6; n++)
            sym4($sformatf("vec%0d", n), vecs[n]);

        tick(1'b0, 1'b0, 0, 0);
        chk("leave RUN busy", int'(busy), 0);
        chk("leave RUN strobe", int'(sym_valid), 0);

        // Calibration to (5,-3), then corrected averages.
        calibrate("cal5", 5, -3, 1'b0);
        tick(1'b1, 1'b0, 0, 0);
        sym4("cal5 zero", mk(5, 5, 5, 5, -3, -3, -3, -3, 0, 0));
        sym4("cal5 plus4", mk(9, 9, 9, 9, -3, -3, -3, -3, 4, 0));

        // Positive saturation: off_I=-100, I=127 gives d=227.
        tick(1'b0, 1'b0, 0, 0);
        calibrate("calm100", -100, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 0);
        sym4("sat pos", mk(127, 127, 127, 127, 0, 0, 0, 0, 127, 0));

        // Negative saturation: off_I=100, I=-128 gives d=-228.
        tick(1'b0, 1'b0, 0, 0);
        calibrate("cal100", 100, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 0);
        sym4("sat neg", mk(-128, -128, -128, -128, 0, 0, 0, 0, -128, 0));

        // Asynchronous reset mid-RUN with nonzero outputs.
        tick(1'b1, 1'b0, -128, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst I_out", int'(I_out), 0);
        chk("midrst busy", int'(busy), 0);
        @(posedge sclk);
        #1;
        chk("midrst sym_valid", int'(sym_valid), 0);
        chk("midrst cal_done", int'(cal_done), 0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 0, 0);
        chk("post rst idle", int'(busy), 0);
        tick(1'b1, 1'b0, 0, 0);
        sym4("post rst offsets zero", mk(33, 33, 33, 33, -7, -7, -7, -7, 33, -7));

        // Abort after two samples; the next symbol uses fresh samples only.
        tick(1'b0, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 50, 50);
        tick(1'b1, 1'b0, 50, 50);
        chk("abort partial no strobe", int'(sym_valid), 0);
        tick(1'b0, 1'b0, 50, 50);
        chk("abort idle", int'(busy), 0);
        chk("abort no strobe", int'(sym_valid), 0);
        tick(1'b1, 1'b0, 50, 50);
        sym4("abort fresh", mk(-8, -8, -8, -8, 12, 12, 12, 12, -8, 12));

        // cal during RUN discards the partial symbol and enters CAL.
        tick(1'b1, 1'b0, 90, 90);
        tick(1'b1, 1'b0, 90, 90);
        en = 1'b1; cal = 1'b1;
        @(posedge sclk);
        #1;
        chk("run->cal busy", int'(busy), 1);
        chk("run->cal no strobe", int'(sym_valid), 0);
        // Already in CAL: feed the 16 samples, no further entry tick.
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, 1'b1, 4, 8);
            chk("run->cal no sym in CAL", int'(sym_valid), 0);
        end
        chk("run->cal cal_done", int'(cal_done), 1);
        tick(1'b0, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 0, 0);
        sym4("cal48", mk(6, 6, 6, 6, 8, 8, 8, 8, 2, 0));

        // cal and en together in IDLE select CAL; restore zero offsets.
        tick(1'b0, 1'b0, 0, 0);
        calibrate("both high", 0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 0);
        sym4("zero offsets", mk(4, 4, 4, 4, -4, -4, -4, -4, 4, -4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    always @(negedge sclk) begin
        if (sym_valid && cal_done) begin
            nerr++;
            $display("FAIL strobe overlap: sym_valid=%0d cal_done=%0d required not both 1", sym_valid, cal_done);
        end
    end

endmodule
